// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared state encoding, widths and type folding for the obstacle scheduler
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } sched_state_t;

    localparam int SPEED_W           = 3;
    localparam int TYPE_W            = 3;
    localparam int DEFAULT_NUM_TYPES = 5;

    // Folds an out-of-range random type back into 0..num_types-1.
    function automatic logic [TYPE_W-1:0] fold_type(input logic [TYPE_W-1:0] t, input int num_types);
        int v;
        v = int'(t);
        if (v >= num_types) begin
            v = v - num_types;
        end
        return TYPE_W'(v);
    endfunction

endpackage

// File: rtl/sched_rr_pick.sv
// rtl/sched_rr_pick.sv - two-requester round-robin picker for obstacle slots
module sched_rr_pick (
    input  logic [1:0] free,
    input  logic       rr_last,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 2'b00;
        if (free == 2'b11) begin
            grant = rr_last ? 2'b01 : 2'b10;
        end else begin
            grant = free;
        end
    end

    assign valid = |free;

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - obstacle launch/slot/type/speed sequencer; SCHED_RAMP_EN builds the speed ramp
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int MIN_GAP    = 40,
    parameter int RAMP_TICKS = 600,
    parameter int MAX_SPEED  = 4,
    parameter int NUM_TYPES  = DEFAULT_NUM_TYPES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_game_tick_60hz,
    input  logic               i_game_start_pulse,
    input  logic               i_game_frozen,
    input  logic [7:0]         i_rng,
    input  logic [1:0]         i_slot_busy,
    output logic [1:0]         o_spawn,
    output logic [TYPE_W-1:0]  o_spawn_type,
    output logic [SPEED_W-1:0] o_speed,
    output logic [1:0]         o_state
);

    sched_state_t state, next_state;
    logic [5:0]   gap;
    logic         rr_last;
    logic [1:0]   grant;
    logic         pick_valid;
    logic         run_tick;
    logic         launch;

    wire unused_rng_bit = i_rng[1];

    sched_rr_pick u_pick (
        .free    (~i_slot_busy),
        .rr_last (rr_last),
        .grant   (grant),
        .valid   (pick_valid)
    );

    // Start outranks tick and frozen; frozen suppresses any counter work that cycle.
    assign run_tick = (state == ST_RUN) && i_game_tick_60hz && !i_game_start_pulse && !i_game_frozen;
    assign launch   = run_tick && (gap == 6'd0) && i_rng[0] && pick_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (i_game_start_pulse) next_state = ST_RUN;
            ST_RUN: begin
                if (i_game_start_pulse)  next_state = ST_RUN;
                else if (i_game_frozen)  next_state = ST_FROZEN;
            end
            ST_FROZEN: if (i_game_start_pulse) next_state = ST_RUN;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap          <= 6'd0;
            rr_last      <= 1'b0;
            o_spawn      <= 2'b00;
            o_spawn_type <= '0;
        end else begin
            o_spawn <= 2'b00;
            if (i_game_start_pulse) begin
                gap     <= 6'(MIN_GAP);
                rr_last <= 1'b1;
            end else if (run_tick) begin
                if (launch) begin
                    gap          <= 6'(MIN_GAP) + {2'b00, i_rng[5:2]};
                    rr_last      <= grant[1];
                    o_spawn      <= grant;
                    o_spawn_type <= fold_type(i_rng[7:5], NUM_TYPES);
                end else if (gap != 6'd0) begin
                    gap <= gap - 6'd1;
                end
            end
        end
    end

`ifdef SCHED_RAMP_EN
    localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    logic [RAMP_W-1:0]  ramp;
    logic [SPEED_W-1:0] speed;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp  <= '0;
            speed <= '0;
        end else if (i_game_start_pulse) begin
            ramp  <= '0;
            speed <= SPEED_W'(1);
        end else if (run_tick) begin
            if (ramp == RAMP_W'(RAMP_TICKS - 1)) begin
                ramp <= '0;
                if (speed != SPEED_W'(MAX_SPEED)) begin
                    speed <= speed + SPEED_W'(1);
                end
            end else begin
                ramp <= ramp + RAMP_W'(1);
            end
        end
    end

    assign o_speed = speed;
`else
    localparam int unused_ramp_cfg = RAMP_TICKS + MAX_SPEED;

    assign o_speed = (state == ST_IDLE) ? '0 : SPEED_W'(1);
`endif

    assign o_state = state;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       frozen = 1'b0;
    logic [7:0] rng = 8'h00;
    logic [1:0] busy = 2'b00;
    logic [1:0] spawn;
    logic [2:0] spawn_type;
    logic [2:0] speed;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [1:0] seen;

`ifdef SCHED_RAMP_EN
    localparam int RT = 4;
    localparam int MS = 3;
`else
    localparam int RT = 600;
    localparam int MS = 4;
`endif

    obstacle_scheduler #(
        .MIN_GAP    (40),
        .RAMP_TICKS (RT),
        .MAX_SPEED  (MS),
        .NUM_TYPES  (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_game_tick_60hz   (tick),
        .i_game_start_pulse (start),
        .i_game_frozen      (frozen),
        .i_rng              (rng),
        .i_slot_busy        (busy),
        .o_spawn            (spawn),
        .o_spawn_type       (spawn_type),
        .o_speed            (speed),
        .o_state            (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle from a negedge; outputs are sampled at the following negedge.
    task automatic cyc(input logic t, input logic s, input logic f, input logic [7:0] r,
                       input logic [1:0] b, input logic rs);
        tick = t; start = s; frozen = f; rng = r; busy = b; rst = rs;
        @(negedge clk);
        tick = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    task automatic idle_ticks(input int n, input logic [7:0] r, input logic [1:0] b);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, r, b, 1'b0);
            seen = seen | spawn;
        end
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
        check("rst_spawn", {6'd0, spawn}, 8'h00);
        check("rst_type",  {5'd0, spawn_type}, 8'h00);
        check("rst_speed", {5'd0, speed}, 8'h00);
        check("rst_state", {6'd0, state}, 8'h00);

        cyc(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        check("start_state", {6'd0, state}, 8'h01);
        check("start_speed", {5'd0, speed}, 8'h01);

        seen = 2'b00;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
            seen = seen | spawn;
`ifdef SCHED_RAMP_EN
            if (i == 3)  check("speed_t3",  {5'd0, speed}, 8'h01);
            if (i == 4)  check("speed_t4",  {5'd0, speed}, 8'h02);
            if (i == 8)  check("speed_t8",  {5'd0, speed}, 8'h03);
            if (i == 12) check("speed_t12", {5'd0, speed}, 8'h03);
`else
            if (i == 4)  check("speed_t4",  {5'd0, speed}, 8'h01);
            if (i == 12) check("speed_t12", {5'd0, speed}, 8'h01);
`endif
        end
        check("no_spawn_gap", {6'd0, seen}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("first_spawn", {6'd0, spawn}, 8'h01);
        check("first_type",  {5'd0, spawn_type}, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("pulse_width", {6'd0, spawn}, 8'h00);

        seen = 2'b00;
        idle_ticks(40, 8'h01, 2'b00);
        check("no_spawn_gap2", {6'd0, seen}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'hE1, 2'b01, 1'b0);
        check("slot1_spawn", {6'd0, spawn}, 8'h02);
        check("slot1_type",  {5'd0, spawn_type}, 8'h02);
        cyc(1'b0, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("type_hold", {5'd0, spawn_type}, 8'h02);

        seen = 2'b00;
        idle_ticks(58, 8'h01, 2'b11);
        check("both_busy", {6'd0, seen}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b10, 1'b0);
        check("release_spawn", {6'd0, spawn}, 8'h01);

        seen = 2'b00;
        idle_ticks(40, 8'h01, 2'b00);
        check("no_spawn_gap3", {6'd0, seen}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("rr_spawn", {6'd0, spawn}, 8'h02);

        idle_ticks(40, 8'h01, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 8'h01, 2'b00, 1'b0);
        check("frz_spawn", {6'd0, spawn}, 8'h00);
        check("frz_state", {6'd0, state}, 8'h02);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("frz_hold", {6'd0, state}, 8'h02);
        check("frz_nospawn", {6'd0, spawn}, 8'h00);

        cyc(1'b1, 1'b1, 1'b1, 8'h01, 2'b00, 1'b0);
        check("restart_state", {6'd0, state}, 8'h01);
        check("restart_speed", {5'd0, speed}, 8'h01);
        check("restart_spawn", {6'd0, spawn}, 8'h00);
        frozen = 1'b0;
        seen = 2'b00;
        idle_ticks(40, 8'h41, 2'b00);
        check("restart_gap", {6'd0, seen}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h41, 2'b00, 1'b0);
        check("restart_launch", {6'd0, spawn}, 8'h01);
        check("restart_type",   {5'd0, spawn_type}, 8'h02);

        idle_ticks(40, 8'h01, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b1);
        check("midrst_spawn", {6'd0, spawn}, 8'h00);
        check("midrst_type",  {5'd0, spawn_type}, 8'h00);
        check("midrst_speed", {5'd0, speed}, 8'h00);
        check("midrst_state", {6'd0, state}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h01, 2'b00, 1'b0);
        check("idle_nospawn", {6'd0, spawn}, 8'h00);
        check("idle_state",   {6'd0, state}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
